// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - light codes and phase encoding shared by the traffic controller
package traffic_pkg;

  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_DARK   = 3'b000;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2,
    PH_FLASH  = 2'd3
  } phase_t;

endpackage

// File: rtl/rr_next_sel.sv
// rtl/rr_next_sel.sv - round-robin search for the first pending direction after base
module rr_next_sel #(
  parameter int NUM_DIR = 4
) (
  input  logic [NUM_DIR-1:0]         pending,
  input  logic [$clog2(NUM_DIR)-1:0] base,
  output logic                       found,
  output logic [$clog2(NUM_DIR)-1:0] idx
);

  localparam int DW = $clog2(NUM_DIR);

  logic [DW-1:0] cand;

  // Walk from the farthest offset back to the nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = NUM_DIR; k >= 1; k--) begin
      cand = DW'((int'(base) + k) % NUM_DIR);
      if (pending[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/traffic_ctrl_multi.sv
// rtl/traffic_ctrl_multi.sv - N-direction demand-actuated traffic controller with flash mode
module traffic_ctrl_multi
  import traffic_pkg::*;
#(
  parameter int NUM_DIR      = 4,
  parameter int CNT_W        = 8,
  parameter int GREEN_TICKS  = 5,
  parameter int YELLOW_TICKS = 1,
  parameter int ALLRED_TICKS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic [NUM_DIR-1:0]         car_req,
  input  logic                       flash_req,
  output logic [3*NUM_DIR-1:0]       light,
  output logic [$clog2(NUM_DIR)-1:0] active_dir,
  output logic [1:0]                 phase
);

  localparam int DW = $clog2(NUM_DIR);
  localparam logic [CNT_W-1:0] G_LOAD = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] Y_LOAD = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] R_LOAD = CNT_W'(ALLRED_TICKS - 1);

  phase_t             state, state_nxt;
  logic [DW-1:0]      dir, dir_nxt, dir_inc;
  logic [CNT_W-1:0]   timer, timer_nxt;
  logic [NUM_DIR-1:0] pending, pending_nxt, dir_mask, set_mask;
  logic               blink, blink_nxt;
  logic               from_flash, from_flash_nxt;
  logic               enter_green, others_pending;
  logic               rr_found;
  logic [DW-1:0]      rr_idx;

  rr_next_sel #(.NUM_DIR(NUM_DIR)) u_rr (
    .pending (pending),
    .base    (dir),
    .found   (rr_found),
    .idx     (rr_idx)
  );

  assign dir_mask       = NUM_DIR'(1) << dir;
  assign set_mask       = (state == PH_GREEN) ? ~dir_mask : '1;
  assign others_pending = |(pending & ~dir_mask);
  assign dir_inc        = (int'(dir) == NUM_DIR - 1) ? '0 : dir + 1'b1;

  always_comb begin
    state_nxt      = state;
    dir_nxt        = dir;
    timer_nxt      = timer;
    blink_nxt      = blink;
    from_flash_nxt = from_flash;
    enter_green    = 1'b0;
    pending_nxt    = pending | (car_req & set_mask);
    if (tick) begin
      case (state)
        PH_GREEN: begin
          if (timer != '0) timer_nxt = timer - 1'b1;
          else if (flash_req || others_pending) begin
            state_nxt = PH_YELLOW;
            timer_nxt = Y_LOAD;
          end
        end
        PH_YELLOW: begin
          if (timer != '0) timer_nxt = timer - 1'b1;
          else begin
            state_nxt = PH_ALLRED;
            timer_nxt = R_LOAD;
          end
        end
        PH_ALLRED: begin
          if (timer != '0) timer_nxt = timer - 1'b1;
          else if (flash_req) begin
            state_nxt = PH_FLASH;
            blink_nxt = 1'b0;
          end else begin
            // Leaving maintenance always restarts service at direction 0.
            state_nxt      = PH_GREEN;
            timer_nxt      = G_LOAD;
            enter_green    = 1'b1;
            from_flash_nxt = 1'b0;
            if (from_flash)    dir_nxt = '0;
            else if (rr_found) dir_nxt = rr_idx;
            else               dir_nxt = dir_inc;
          end
        end
        PH_FLASH: begin
          blink_nxt = ~blink;
          if (!flash_req) begin
            state_nxt      = PH_ALLRED;
            timer_nxt      = R_LOAD;
            from_flash_nxt = 1'b1;
          end
        end
        default: begin
          state_nxt = PH_ALLRED;
          timer_nxt = R_LOAD;
        end
      endcase
    end
    if (enter_green) pending_nxt[dir_nxt] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= PH_GREEN;
      dir        <= '0;
      timer      <= G_LOAD;
      pending    <= '0;
      blink      <= 1'b0;
      from_flash <= 1'b0;
    end else begin
      state      <= state_nxt;
      dir        <= dir_nxt;
      timer      <= timer_nxt;
      pending    <= pending_nxt;
      blink      <= blink_nxt;
      from_flash <= from_flash_nxt;
    end
  end

  always_comb begin
    light = '0;
    for (int d = 0; d < NUM_DIR; d++) begin
      case (state)
        PH_GREEN:  light[3*d +: 3] = (int'(dir) == d) ? LIGHT_GREEN : LIGHT_RED;
        PH_YELLOW: light[3*d +: 3] = (int'(dir) == d) ? LIGHT_YELLOW : LIGHT_RED;
        PH_FLASH:  light[3*d +: 3] = blink ? LIGHT_RED : LIGHT_DARK;
        default:   light[3*d +: 3] = LIGHT_RED;
      endcase
    end
  end

  assign active_dir = dir;
  assign phase      = state;

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// tb/tb_traffic_ctrl_multi.sv - randomized scoreboard bench for traffic_ctrl_multi
module tb_traffic_ctrl_multi;

  localparam int N = 4;
  localparam int G = 5;
  localparam int Y = 1;
  localparam int R = 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           tick;
  logic [N-1:0]   car_req;
  logic           flash_req;
  logic [3*N-1:0] light;
  logic [1:0]     active_dir;
  logic [1:0]     phase;

  always #5 clk = ~clk;

  traffic_ctrl_multi #(
    .NUM_DIR(N), .CNT_W(8), .GREEN_TICKS(G), .YELLOW_TICKS(Y), .ALLRED_TICKS(R)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .car_req    (car_req),
    .flash_req  (flash_req),
    .light      (light),
    .active_dir (active_dir),
    .phase      (phase)
  );

  typedef struct packed {
    logic [3*N-1:0] light;
    logic [1:0]     dir;
    logic [1:0]     phase;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Reference model: phase as 0..3, ticks already spent in the phase, demand set.
  int       m_phase, m_dir, m_el;
  bit [N-1:0] m_pend;
  bit       m_blink, m_ff;

  function automatic exp_t expected();
    exp_t e;
    logic [2:0] c;
    e.light = '0;
    for (int d = 0; d < N; d++) begin
      if (m_phase == 0)      c = (d == m_dir) ? 3'b001 : 3'b100;
      else if (m_phase == 1) c = (d == m_dir) ? 3'b010 : 3'b100;
      else if (m_phase == 3) c = m_blink ? 3'b100 : 3'b000;
      else                   c = 3'b100;
      e.light[3*d +: 3] = c;
    end
    e.dir   = 2'(m_dir);
    e.phase = 2'(m_phase);
    return e;
  endfunction

  task automatic model_step(input logic r, input logic t, input logic [N-1:0] c, input logic f);
    bit [N-1:0] np;
    bit others;
    int nxt;
    if (!r) begin
      m_phase = 0; m_dir = 0; m_el = 0; m_pend = '0; m_blink = 0; m_ff = 0;
      return;
    end
    np = m_pend;
    for (int d = 0; d < N; d++)
      if (c[d] && (m_phase != 0 || d != m_dir)) np[d] = 1'b1;
    others = 1'b0;
    for (int d = 0; d < N; d++)
      if (m_pend[d] && d != m_dir) others = 1'b1;
    if (t) begin
      case (m_phase)
        0: if (m_el < G - 1) m_el++;
           else if (f || others) begin m_phase = 1; m_el = 0; end
        1: if (m_el < Y - 1) m_el++;
           else begin m_phase = 2; m_el = 0; end
        2: if (m_el < R - 1) m_el++;
           else if (f) begin m_phase = 3; m_blink = 0; end
           else begin
             nxt = (m_dir + 1) % N;
             if (m_ff) nxt = 0;
             else begin
               for (int k = 1; k <= N; k++)
                 if (m_pend[(m_dir + k) % N]) begin nxt = (m_dir + k) % N; break; end
             end
             m_phase = 0; m_dir = nxt; m_el = 0; m_ff = 0; np[nxt] = 1'b0;
           end
        default: begin
          m_blink = !m_blink;
          if (!f) begin m_phase = 2; m_el = 0; m_ff = 1; end
        end
      endcase
    end
    m_pend = np;
  endtask

  task automatic cycle(input logic r, input logic t, input logic [N-1:0] c, input logic f);
    rst = r; tick = t; car_req = c; flash_req = f;
    @(posedge clk);
    model_step(r, t, c, f);
    expq.push_back(expected());
    cyc++;
    #1;
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      mon_e = expq.pop_front();
      checks++;
      if ({light, active_dir, phase} !== mon_e) begin
        failures++;
        if (failures <= 20)
          $display("FAIL scoreboard cycle=%0d light got=%h want=%h dir got=%0d want=%0d phase got=%0d want=%0d",
                   cyc, light, mon_e.light, active_dir, mon_e.dir, phase, mon_e.phase);
      end
    end
  end

  logic [N-1:0] r_req;
  logic         r_fl;

  initial begin
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, '0, 1'b0);
    // Continuous demand on every approach: full rotation 0->1->2->3->0.
    for (int i = 0; i < 60; i++) cycle(1'b1, 1'b1, '1, 1'b0);
    // Drain, then a lone request skips intermediate directions and rests.
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, '0, 1'b0);
    cycle(1'b1, 1'b1, 4'b0100, 1'b0);
    for (int i = 0; i < 30; i++) cycle(1'b1, 1'b1, '0, 1'b0);
    // Request for the green owner is ignored; the other one is served.
    cycle(1'b1, 1'b1, 4'b1100, 1'b0);
    for (int i = 0; i < 30; i++) cycle(1'b1, 1'b1, '0, 1'b0);
    // Maintenance flash entered mid-green, then released.
    cycle(1'b1, 1'b1, 4'b0010, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, '0, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, '0, 1'b0);
    // Reset mid-rotation with demand latched.
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 4'b0101, 1'b0);
    cycle(1'b0, 1'b1, 4'b0101, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, '0, 1'b0);
    // Sparse tick: timers move only on strobe cycles.
    for (int i = 0; i < 120; i++) cycle(1'b1, (i % 4) == 3, '1, 1'b0);
    // Randomized traffic, ticks, flash windows and occasional resets.
    r_fl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      r_req = '0;
      for (int d = 0; d < N; d++) if ($urandom_range(15) == 0) r_req[d] = 1'b1;
      if (r_fl) begin
        if ($urandom_range(39) == 0) r_fl = 1'b0;
      end else if ($urandom_range(299) == 0) r_fl = 1'b1;
      cycle($urandom_range(799) != 0, $urandom_range(1) == 1, r_req, r_fl);
    end
    @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain leftover=%0d required=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
